vc_dff_pipe: RTL

//  - Parametrised multi-stage flip-flop pipeline: successor to the single positive-edge DFF.
//  - Carries a W-bit word plus a valid bit through DEPTH stages; supports stall, flush and an occupancy count.
//  - Used as a retiming/delay line between FFT datapath stages and to align control with data.

---
 rtl/vc_dff_pipe_pkg.sv | 23 ++
 rtl/vc_dff_pipe_if.sv | 30 +++
 rtl/vc_dff_pipe_stage.sv | 32 +++
 rtl/vc_dff_pipe.sv | 92 +++++++++
 4 files changed

// File: rtl/vc_dff_pipe_pkg.sv
// Shared constants and helpers for the vc_dff_pipe delay line.
// Stage words are packed as {parity, val, data} with data at the LSBs.
package vc_pipe_pkg;

  localparam int VC_PIPE_MIN_DEPTH = 1;
  localparam int DATA_LSB = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int valOfs(input int w);
    return DATA_LSB + w;
  endfunction

  function automatic int parOfs(input int w);
    return DATA_LSB + w + 1;
  endfunction

endpackage

// File: rtl/vc_dff_pipe_if.sv
// Pipeline control/data bundle for vc_dff_pipe.
// master drives the input side, slave is the pipeline itself.
interface vc_dff_pipe_if
  import vc_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = clog2(DEPTH + 1);

  logic          en_p;
  logic          flush_p;
  logic [W-1:0]  d_p;
  logic          d_val_p;
  logic [W-1:0]  q_np;
  logic          q_val_np;
  logic [CW-1:0] count_np;
  logic          perr_np;

  modport master (
    output en_p, flush_p, d_p, d_val_p,
    input  q_np, q_val_np, count_np, perr_np
  );

  modport slave (
    input  en_p, flush_p, d_p, d_val_p,
    output q_np, q_val_np, count_np, perr_np
  );

endinterface

// File: rtl/vc_dff_pipe_stage.sv
// One pipeline register: async active-low reset, advance enable,
// and a synchronous clear that drops only the valid bit.
module vc_dff_pipe_stage
  import vc_pipe_pkg::*;
#(
  parameter int SW      = 33,
  parameter int VAL_BIT = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stageEn,
  input  logic          validClr,
  input  logic [SW-1:0] dIn,
  output logic [SW-1:0] dOut
);

  logic [SW-1:0] stageQ;

  // Clear wins over enable; data bits are left untouched on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stageQ <= '0;
    end else if (validClr) begin
      stageQ[VAL_BIT] <= 1'b0;
    end else if (stageEn) begin
      stageQ <= dIn;
    end
  end

  assign dOut = stageQ;

endmodule

// File: rtl/vc_dff_pipe.sv
// DEPTH-stage data+valid delay line with stall, flush and occupancy count.
// Optional output parity check enabled by VC_DFF_PIPE_PARITY_EN.
module vc_dff_pipe
  import vc_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  vc_dff_pipe_if.slave pipeIf
);

  localparam int CW      = clog2(DEPTH + 1);
  localparam int VAL_BIT = valOfs(W);
`ifdef VC_DFF_PIPE_PARITY_EN
  localparam int PAR_BIT = parOfs(W);
  localparam int SW      = PAR_BIT + 1;
`else
  localparam int SW      = VAL_BIT + 1;
`endif

  logic [SW-1:0] stageIn  [DEPTH];
  logic [SW-1:0] stageOut [DEPTH];
  logic [SW-1:0] lastStage;
  logic          lastVal;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;

  if (DEPTH < VC_PIPE_MIN_DEPTH) begin : gBadDepth
    $error("vc_dff_pipe: DEPTH must be at least 1");
  end

`ifdef VC_DFF_PIPE_PARITY_EN
  // Even parity is captured once at entry and then travels with the word.
  assign stageIn[0] = {^pipeIf.d_p, pipeIf.d_val_p, pipeIf.d_p};
`else
  assign stageIn[0] = {pipeIf.d_val_p, pipeIf.d_p};
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    if (i > 0) begin : gLink
      assign stageIn[i] = stageOut[i-1];
    end
    vc_dff_pipe_stage #(
      .SW      (SW),
      .VAL_BIT (VAL_BIT)
    ) uStage (
      .clk      (clk),
      .reset_n  (reset_n),
      .stageEn  (pipeIf.en_p),
      .validClr (pipeIf.flush_p),
      .dIn      (stageIn[i]),
      .dOut     (stageOut[i])
    );
  end

  assign lastStage = stageOut[DEPTH-1];
  assign lastVal   = lastStage[VAL_BIT];

  // Incremental occupancy: one word in and one out leaves the count alone.
  always_comb begin
    countNext = count;
    if (pipeIf.d_val_p && !lastVal) begin
      countNext = count + CW'(1);
    end else if (!pipeIf.d_val_p && lastVal) begin
      countNext = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (pipeIf.flush_p) begin
      count <= '0;
    end else if (pipeIf.en_p) begin
      count <= countNext;
    end
  end

  assign pipeIf.q_np     = lastStage[DATA_LSB +: W];
  assign pipeIf.q_val_np = lastVal;
  assign pipeIf.count_np = count;

`ifdef VC_DFF_PIPE_PARITY_EN
  // Derived only from last-stage flops, so it updates on the same edge as q_np.
  assign pipeIf.perr_np = lastVal & ((^lastStage[DATA_LSB +: W]) != lastStage[PAR_BIT]);
`else
  assign pipeIf.perr_np = 1'b0;
`endif

endmodule
